// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative multiply/divide unit holding the architectural HI/LO registers.
//   MULT/MULTU use shift-add and DIV/DIVU use restoring division, one bit per
//   cycle. A final FIX cycle applies the sign correction and writes HI/LO.
//   MTHI/MTLO writes are accepted while idle. A flush abandons an in-flight op.
//
// Ports
//   clk      in   clock, rising edge
//   reset_n  in   synchronous active-low reset
//   start    in   request an operation (taken only while busy=0)
//   op       in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a        in   rs operand (multiplicand / dividend)
//   b        in   rt operand (multiplier / divisor)
//   flush    in   abort an in-flight operation
//   hi_we    in   MTHI write enable
//   lo_we    in   MTLO write enable
//   wdata    in   MTHI/MTLO data
//   busy     out  operation in progress (RUN or FIX)
//   done     out  one-cycle pulse when HI/LO take a completed result
//   dz       out  with done: the completed op divided by zero
//   hi       out  HI register
//   lo       out  LO register
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              is_div_q, is_div_d;
  logic              neg_q, neg_d;
  logic              sign_a_q, sign_a_d;
  logic              div_zero_q, div_zero_d;
  logic [WIDTH-1:0]  mag_a_q, mag_a_d;
  logic [WIDTH-1:0]  mag_b_q, mag_b_d;
  logic [WIDTH-1:0]  raw_a_q, raw_a_d;
  logic [WIDTH-1:0]  hi_acc_q, hi_acc_d;
  logic [WIDTH-1:0]  lo_acc_q, lo_acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dz_q, dz_d;

  // Operand decode at accept time. Unsigned ops use the raw operands, so the
  // sign bits are forced to zero and no fixup ever happens for them.
  logic              op_signed;
  logic              in_sign_a, in_sign_b;
  logic [WIDTH-1:0]  in_mag_a, in_mag_b;

  assign op_signed = ~op[0];
  assign in_sign_a = op_signed & a[WIDTH-1];
  assign in_sign_b = op_signed & b[WIDTH-1];
  // Negating the most-negative value yields the same bit pattern, which read
  // as unsigned is exactly its magnitude, so no special case is needed.
  assign in_mag_a  = in_sign_a ? (~a + 1'b1) : a;
  assign in_mag_b  = in_sign_b ? (~b + 1'b1) : b;

  // Multiply step: {hi_acc, lo_acc} starts as {0, |b|}; each step adds |a| to
  // the upper half when the current multiplier bit is set, then shifts right.
  logic [WIDTH:0]    mul_sum;
  assign mul_sum = lo_acc_q[0] ? ({1'b0, hi_acc_q} + {1'b0, mag_a_q})
                               : {1'b0, hi_acc_q};

  // Divide step: hi_acc holds the partial remainder, lo_acc shifts the
  // dividend out at the top while quotient bits shift in at the bottom.
  // The remainder stays below the divisor, so the top bit of the difference
  // is a clean borrow flag.
  logic [WIDTH:0]    div_shift;
  logic [WIDTH:0]    div_diff;
  assign div_shift = {hi_acc_q, lo_acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mag_b_q};

  // Sign fixup applied in FIX.
  logic [2*WIDTH-1:0] mul_prod;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   quo_res;
  logic [WIDTH-1:0]   rem_res;
  assign mul_prod = {hi_acc_q, lo_acc_q};
  assign mul_res  = neg_q    ? (~mul_prod + 1'b1) : mul_prod;
  assign quo_res  = neg_q    ? (~lo_acc_q + 1'b1) : lo_acc_q;
  assign rem_res  = sign_a_q ? (~hi_acc_q + 1'b1) : hi_acc_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      sign_a_q   <= 1'b0;
      div_zero_q <= 1'b0;
      mag_a_q    <= '0;
      mag_b_q    <= '0;
      raw_a_q    <= '0;
      hi_acc_q   <= '0;
      lo_acc_q   <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      sign_a_q   <= sign_a_d;
      div_zero_q <= div_zero_d;
      mag_a_q    <= mag_a_d;
      mag_b_q    <= mag_b_d;
      raw_a_q    <= raw_a_d;
      hi_acc_q   <= hi_acc_d;
      lo_acc_q   <= lo_acc_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dz_q       <= dz_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    sign_a_d   = sign_a_q;
    div_zero_d = div_zero_q;
    mag_a_d    = mag_a_q;
    mag_b_d    = mag_b_q;
    raw_a_d    = raw_a_q;
    hi_acc_d   = hi_acc_q;
    lo_acc_d   = lo_acc_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dz_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        // A flush in the same cycle drops the start request.
        if (start && !flush) begin
          is_div_d   = op[1];
          neg_d      = in_sign_a ^ in_sign_b;
          sign_a_d   = in_sign_a;
          div_zero_d = op[1] && (b == '0);
          mag_a_d    = in_mag_a;
          mag_b_d    = in_mag_b;
          raw_a_d    = a;
          hi_acc_d   = '0;
          lo_acc_d   = op[1] ? in_mag_a : in_mag_b;
          cnt_d      = '0;
          state_d    = RUN;
        end
      end

      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
              hi_acc_d = div_diff[WIDTH-1:0];
              lo_acc_d = {lo_acc_q[WIDTH-2:0], 1'b1};
            end else begin
              hi_acc_d = div_shift[WIDTH-1:0];
              lo_acc_d = {lo_acc_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            hi_acc_d = mul_sum[WIDTH:1];
            lo_acc_d = {mul_sum[0], lo_acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) state_d = FIX;
        end
      end

      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          done_d = 1'b1;
          dz_d   = div_zero_q;
          if (!is_div_q) begin
            hi_d = mul_res[2*WIDTH-1:WIDTH];
            lo_d = mul_res[WIDTH-1:0];
          end else if (div_zero_q) begin
            hi_d = raw_a_q;
            lo_d = '1;
          end else begin
            hi_d = rem_res;
            lo_d = quo_res;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
